// File: rtl/clz_pkg.sv
// Shared types and defaults for the sequential leading-zero counter/normaliser.
package clz_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDone
   } clz_state_e;

   localparam int unsigned DEFAULT_WIDTH = 64;
   localparam int unsigned DEFAULT_CHUNK = 16;

   // Count width able to represent 0..w inclusive.
   function automatic int unsigned count_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/clz.sv
// Combinational leading-zero detector; valid flags a non-zero input word.
module clz #(
   parameter int unsigned W    = 16,
   parameter int unsigned CNTW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]    data,
   output logic [CNTW-1:0] count,
   output logic            valid
);

   // Ascending scan: the highest set bit is the last to write count.
   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         if (data[i]) begin
            count = CNTW'(W - 1 - i);
         end
      end
   end

   assign valid = |data;

endmodule

// File: rtl/clz_seq_norm.sv
// Multi-cycle leading-zero counter scanning MSB-first one chunk per cycle.
// Define CLZ_SEQ_NORM_SHIFT_EN to left-normalise out_data; otherwise it echoes the operand.
module clz_seq_norm
   import clz_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned CHUNK  = DEFAULT_CHUNK,
   parameter int unsigned NCHUNK = WIDTH / CHUNK,
   parameter int unsigned CW     = count_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_zero,
   output logic [WIDTH-1:0] out_data
);

   localparam int unsigned IW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned CCW = $clog2(CHUNK);

   clz_state_e       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    out_count_q, out_count_d;
   logic             out_zero_q, out_zero_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   logic [WIDTH-1:0] data_aligned;
   logic [CHUNK-1:0] chunk;
   logic [CCW-1:0]   chunk_clz;
   logic             chunk_nz;
   logic [CW-1:0]    scan_count;
   logic [WIDTH-1:0] norm_data;

   // Bring the current chunk to the top so a constant part-select picks it.
   assign data_aligned = data_q << (idx_q * CHUNK);
   assign chunk        = data_aligned[WIDTH-1 -: CHUNK];
   assign scan_count   = CW'(idx_q * CHUNK) + CW'(chunk_clz);

   clz #(
      .W    (CHUNK),
      .CNTW (CCW)
   ) u_clz (
      .data  (chunk),
      .count (chunk_clz),
      .valid (chunk_nz)
   );

`ifdef CLZ_SEQ_NORM_SHIFT_EN
   assign norm_data = data_q << scan_count;
`else
   assign norm_data = data_q;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      data_d      = data_q;
      out_valid_d = out_valid_q;
      out_count_d = out_count_q;
      out_zero_d  = out_zero_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = in_data;
               idx_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (chunk_nz) begin
               out_count_d = scan_count;
               out_zero_d  = 1'b0;
               out_data_d  = norm_data;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end else if (idx_q == IW'(NCHUNK - 1)) begin
               out_count_d = CW'(WIDTH);
               out_zero_d  = 1'b1;
               out_data_d  = '0;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         out_zero_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         out_zero_q  <= out_zero_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !rst;
   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign out_zero  = out_zero_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_clz_seq_norm.sv
// Scoreboard bench for clz_seq_norm: driver queues expectations, monitor checks results.
module tb_clz_seq_norm;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_count;
   logic        out_zero;
   logic [63:0] out_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [6:0]  cnt;
      logic        z;
      logic [63:0] dat;
      int          lat;
      int          edge_no;
   } exp_t;

   typedef struct {
      logic [63:0] d;
      logic [6:0]  cnt;
      logic        z;
      logic [63:0] shifted;
      int          lat;
   } vec_t;

   exp_t q[$];
   exp_t cur;
   bit   seen = 1'b0;

   clz_seq_norm dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_zero  (out_zero),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send(input vec_t v, input bit expect_out);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_wait: in_ready=%b want 1", in_ready);
         return;
      end
      in_valid = 1'b1;
      in_data  = v.d;
      if (expect_out) begin
         e.cnt = v.cnt;
         e.z   = v.z;
`ifdef CLZ_SEQ_NORM_SHIFT_EN
         e.dat = v.shifted;
`else
         e.dat = v.d;
`endif
         e.lat     = v.lat;
         e.edge_no = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || out_valid || !in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (q.size() != 0 || out_valid) begin
         bad++;
         $display("FAIL drain: pending=%0d out_valid=%b want 0/0", q.size(), out_valid);
      end
   endtask

   // Monitor: pops on the first cycle a result is shown, then checks it stays put.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!seen) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_out: out_valid=1 count=%0d want no result", out_count);
            end else begin
               cur = q.pop_front();
               seen = 1'b1;
               check("count", 64'(out_count), 64'(cur.cnt));
               check("zero", 64'(out_zero), 64'(cur.z));
               check("data", out_data, cur.dat);
               check("latency", 64'(cyc - cur.edge_no), 64'(cur.lat));
            end
         end else begin
            check("hold_count", 64'(out_count), 64'(cur.cnt));
            check("hold_data", out_data, cur.dat);
            check("busy_in_ready", 64'(in_ready), 64'd0);
         end
         if (out_ready) seen = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   vec_t vecs[9];
   vec_t vz, vf0;

   initial begin
      vecs[0] = '{64'h8000_0000_0000_0000, 7'd0,  1'b0, 64'h8000_0000_0000_0000, 1};
      vecs[1] = '{64'h0000_0000_0001_0000, 7'd47, 1'b0, 64'h8000_0000_0000_0000, 3};
      vecs[2] = '{64'h0000_0000_0000_0000, 7'd64, 1'b1, 64'h0000_0000_0000_0000, 4};
      vecs[3] = '{64'h0000_00F0_0000_0000, 7'd24, 1'b0, 64'hF000_0000_0000_0000, 2};
      vecs[4] = '{64'h0000_0000_0000_0001, 7'd63, 1'b0, 64'h8000_0000_0000_0000, 4};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[6] = '{64'h0123_4567_89AB_CDEF, 7'd7,  1'b0, 64'h91A2_B3C4_D5E6_F780, 1};
      vecs[7] = '{64'h0000_0001_0000_0000, 7'd31, 1'b0, 64'h8000_0000_0000_0000, 2};
      vecs[8] = '{64'h0000_0000_8000_0000, 7'd32, 1'b0, 64'h8000_0000_0000_0000, 3};
      vz  = vecs[2];
      vf0 = vecs[3];

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_out_zero", 64'(out_zero), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // Directed vectors with a free-running consumer.
      for (int i = 0; i < 9; i++) begin
         send(vecs[i], 1'b1);
         wait_idle();
      end

      // Backpressure: result held while the consumer stalls.
      out_ready = 1'b0;
      send(vf0, 1'b1);
      for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_valid", 64'(out_valid), 64'd0);
      wait_idle();

      // Reset in the second scan cycle of an all-zero operand.
      send(vz, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_in_ready", 64'(in_ready), 64'd1);
      for (int n = 0; n < 6; n++) begin
         check("postrst_no_valid", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      send(vf0, 1'b1);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
